// File: rtl/spatial_gate_fusion_unit_pkg.sv
// Shared types and constants for the spatial gate fusion unit.
package spatial_gate_fusion_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATE_RD,
    S_GATE_CAP,
    S_CH_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_IN_CH     = 8;
  localparam int DEF_K_DIM     = 3;
  localparam int DEF_IMG_W     = 5;
  localparam int DEF_IMG_H     = 4;
  localparam int DEF_FM_ADDR_W = 10;
  localparam int DEF_GATE_FRAC = 6;

  // Number of kernel positions that fit fully inside the feature map.
  function automatic int calcVp(input int imgH, input int imgW, input int kDim);
    return (imgH - kDim + 1) * (imgW - kDim + 1);
  endfunction

  // Offset from a kernel's top-left corner to its centre tap.
  function automatic int calcKOff(input int kDim);
    return kDim / 2;
  endfunction

  localparam int VP        = calcVp(DEF_IMG_H, DEF_IMG_W, DEF_K_DIM);
  localparam int OUT_COUNT = VP * DEF_IN_CH;
  localparam int K_OFF     = calcKOff(DEF_K_DIM);

endpackage

// File: rtl/spatial_gate_fusion_unit_gate_mul_sat.sv
// Registered multiply / round-half-up / saturate stage; address and valid
// travel alongside the sample so the write port lines up with the data.
module gate_mul_sat #(
  parameter int DATA_W    = 8,
  parameter int GATE_FRAC = 6,
  parameter int ADDR_W    = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     valid_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic signed [DATA_W-1:0] fm_i,
  input  logic signed [DATA_W-1:0] gate_i,
  output logic                     valid_o,
  output logic [ADDR_W-1:0]        addr_o,
  output logic signed [DATA_W-1:0] data_o
);

  // One spare bit so the rounding constant can never overflow the product.
  localparam int PW   = 2 * DATA_W + 1;
  localparam int MAXI = (1 << (DATA_W - 1)) - 1;
  localparam logic signed [PW-1:0] RND  = (GATE_FRAC > 0) ? (PW'(1) << (GATE_FRAC - 1)) : '0;
  localparam logic signed [PW-1:0] MAXV = PW'(MAXI);
  localparam logic signed [PW-1:0] MINV = PW'(-MAXI - 1);

  logic signed [PW-1:0]     prod;
  logic signed [PW-1:0]     rounded;
  logic signed [PW-1:0]     shifted;
  logic signed [DATA_W-1:0] satD;

  logic                     valid_q;
  logic [ADDR_W-1:0]        addr_q;
  logic signed [DATA_W-1:0] data_q;

  // Full-precision product, rounded and clamped back to the sample range.
  always_comb begin
    prod    = PW'(fm_i) * PW'(gate_i);
    rounded = prod + RND;
    shifted = rounded >>> GATE_FRAC;
    if (shifted > MAXV) begin
      satD = MAXV[DATA_W-1:0];
    end else if (shifted < MINV) begin
      satD = MINV[DATA_W-1:0];
    end else begin
      satD = shifted[DATA_W-1:0];
    end
  end

  // Output register; valid is a one-enabled-cycle strobe per sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        addr_q <= addr_i;
        data_q <= satD;
      end
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/spatial_gate_fusion_unit.sv
// Walks every valid kernel centre, fetches one gate per pixel and scales all
// channels of the centre feature by it, writing the gated samples out in order.
module spatial_gate_fusion_unit
  import spatial_gate_fusion_unit_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int IN_CH     = DEF_IN_CH,
  parameter int K_DIM     = DEF_K_DIM,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int FM_ADDR_W = DEF_FM_ADDR_W,
  parameter int GATE_FRAC = DEF_GATE_FRAC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_clk_en,
  input  logic                        i_start,
  output logic                        o_done,
  output logic                        o_busy,
  output logic                        o_fm_rd_en,
  output logic [FM_ADDR_W-1:0]        o_fm_rd_addr,
  input  logic signed [DATA_W-1:0]    i_fm_rd_data,
  output logic [FM_ADDR_W-1:0]        o_gate_rd_addr,
  input  logic signed [DATA_W-1:0]    i_gate_rd_data,
  output logic                        o_out_wr_en,
  output logic [FM_ADDR_W-1:0]        o_out_wr_addr,
  output logic signed [DATA_W-1:0]    o_out_wr_data
);

  localparam int VP_L  = calcVp(IMG_H, IMG_W, K_DIM);
  localparam int OUT_L = VP_L * IN_CH;
  localparam int CH_W  = (IN_CH > 1) ? $clog2(IN_CH) : 1;

  localparam logic [FM_ADDR_W-1:0] ONE_A    = FM_ADDR_W'(1);
  localparam logic [FM_ADDR_W-1:0] KOFF_A   = FM_ADDR_W'(calcKOff(K_DIM));
  localparam logic [FM_ADDR_W-1:0] IMGW_A   = FM_ADDR_W'(IMG_W);
  localparam logic [FM_ADDR_W-1:0] INCH_A   = FM_ADDR_W'(IN_CH);
  localparam logic [FM_ADDR_W-1:0] COL_LAST = FM_ADDR_W'(IMG_W - K_DIM);
  localparam logic [FM_ADDR_W-1:0] PIX_LAST = FM_ADDR_W'(VP_L - 1);
  localparam logic [FM_ADDR_W-1:0] OUT_LAST = FM_ADDR_W'(OUT_L - 1);
  localparam logic [CH_W-1:0]      CH_LAST  = CH_W'(IN_CH - 1);
  localparam logic [CH_W-1:0]      CH_ONE   = CH_W'(1);

  state_e                   state_q, state_d;
  logic [FM_ADDR_W-1:0]     row_q, row_d;
  logic [FM_ADDR_W-1:0]     col_q, col_d;
  logic [FM_ADDR_W-1:0]     pix_q, pix_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic signed [DATA_W-1:0] gate_q, gate_d;
  logic                     rdValid_q;
  logic [FM_ADDR_W-1:0]     rdOutAddr_q;

  logic                     fmRdEn;
  logic [FM_ADDR_W-1:0]     fmAddr;
  logic [FM_ADDR_W-1:0]     outAddrNow;
  logic                     mulValid;
  logic [FM_ADDR_W-1:0]     mulAddr;
  logic signed [DATA_W-1:0] mulData;

  assign fmRdEn     = (state_q == S_CH_RUN);
  assign fmAddr     = ((row_q + KOFF_A) * IMGW_A + col_q + KOFF_A) * INCH_A + FM_ADDR_W'(ch_q);
  assign outAddrNow = pix_q * INCH_A + FM_ADDR_W'(ch_q);

  // Sequencer: gate fetch, gate capture, one feature read per channel; the
  // gate only changes two cycles after the previous pixel's last read.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    pix_d   = pix_q;
    ch_d    = ch_q;
    gate_d  = gate_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_GATE_RD;
          row_d   = '0;
          col_d   = '0;
          pix_d   = '0;
          ch_d    = '0;
        end
      end
      S_GATE_RD: begin
        state_d = S_GATE_CAP;
      end
      S_GATE_CAP: begin
        gate_d  = i_gate_rd_data;
        ch_d    = '0;
        state_d = S_CH_RUN;
      end
      S_CH_RUN: begin
        if (ch_q == CH_LAST) begin
          ch_d = '0;
          if (pix_q == PIX_LAST) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_GATE_RD;
            pix_d   = pix_q + ONE_A;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + ONE_A;
            end else begin
              col_d = col_q + ONE_A;
            end
          end
        end else begin
          ch_d = ch_q + CH_ONE;
        end
      end
      S_DRAIN: begin
        if (mulValid && (mulAddr == OUT_LAST)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, gate register and the read-return pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      pix_q       <= '0;
      ch_q        <= '0;
      gate_q      <= '0;
      rdValid_q   <= 1'b0;
      rdOutAddr_q <= '0;
    end else if (i_clk_en) begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pix_q       <= pix_d;
      ch_q        <= ch_d;
      gate_q      <= gate_d;
      rdValid_q   <= fmRdEn;
      rdOutAddr_q <= outAddrNow;
    end
  end

  gate_mul_sat #(
    .DATA_W    (DATA_W),
    .GATE_FRAC (GATE_FRAC),
    .ADDR_W    (FM_ADDR_W)
  ) u_gate_mul_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (i_clk_en),
    .valid_i (rdValid_q),
    .addr_i  (rdOutAddr_q),
    .fm_i    (i_fm_rd_data),
    .gate_i  (gate_q),
    .valid_o (mulValid),
    .addr_o  (mulAddr),
    .data_o  (mulData)
  );

  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = (state_q == S_DONE);
  assign o_fm_rd_en     = fmRdEn;
  assign o_fm_rd_addr   = fmRdEn ? fmAddr : '0;
  assign o_gate_rd_addr = pix_q;
  assign o_out_wr_en    = mulValid;
  assign o_out_wr_addr  = mulAddr;
  assign o_out_wr_data  = mulData;

endmodule

// File: doc/spatial_gate_fusion_unit.md
SPATIAL_GATE_FUSION_UNIT -- requirements
Module: spatial_gate_fusion_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the feature, gate and output sample width.
REQ-002 SHALL have parameter IN_CH, default 8, meaning the channels per pixel.
REQ-003 SHALL have parameter K_DIM, default 3, meaning the gate kernel size; the valid region is (IMG_H-K_DIM+1) x (IMG_W-K_DIM+1).
REQ-004 SHALL have parameters IMG_W, default 5, and IMG_H, default 4, meaning the feature-map width and height.
REQ-005 SHALL have parameter FM_ADDR_W, default 10, meaning the width of all address ports.
REQ-006 SHALL have parameter GATE_FRAC, default 6, meaning the gate fraction bits (gate 2^GATE_FRAC = 1.0).
REQ-007 Ports, as name, direction, width, meaning:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous active-low reset.
- i_clk_en, in, 1: global advance enable.
- i_start, in, 1: start request.
- o_done, out, 1: completion pulse.
- o_busy, out, 1: high in any non-IDLE state.
- o_fm_rd_en, out, 1: feature-buffer read strobe.
- o_fm_rd_addr, out, FM_ADDR_W: feature-buffer address.
- i_fm_rd_data, in, DATA_W signed: feature data, 1-cycle read latency.
- o_gate_rd_addr, out, FM_ADDR_W: gate-BRAM address.
- i_gate_rd_data, in, DATA_W signed: gate data, 1-cycle read latency.
- o_out_wr_en, out, 1: output-buffer write strobe.
- o_out_wr_addr, out, FM_ADDR_W: output-buffer address.
- o_out_wr_data, out, DATA_W signed: gated sample.

Function
REQ-008 SHALL advance all state, counters and registers only on edges where i_clk_en=1; with i_clk_en=0 every output holds its value.
REQ-009 SHALL have the states IDLE, GATE_RD, GATE_CAP, CH_RUN, DRAIN and DONE.
REQ-010 SHALL leave IDLE for GATE_RD on i_start=1 and ignore i_start in every other state.
REQ-011 SHALL iterate valid pixel p=(r,c) in row-major order, with p from 0 to VP-1 where VP=(IMG_H-K_DIM+1)*(IMG_W-K_DIM+1).
REQ-012 GATE_RD SHALL drive o_gate_rd_addr=p; GATE_CAP SHALL latch i_gate_rd_data into gate_reg and move to CH_RUN.
REQ-013 CH_RUN SHALL issue, over IN_CH consecutive cycles, o_fm_rd_en=1 with o_fm_rd_addr=((r+K_DIM/2)*IMG_W+(c+K_DIM/2))*IN_CH+ch for ch=0..IN_CH-1.
REQ-014 After the last channel, CH_RUN SHALL go to GATE_RD for the next pixel, or to DRAIN after pixel VP-1; each pixel therefore costs IN_CH+2 enabled cycles.
REQ-015 Pipeline: a read issued in enabled cycle t returns data at t+1, where the product is computed and registered; o_out_wr_en=1 in cycle t+2 with o_out_wr_addr=p*IN_CH+ch.
REQ-016 SHALL form o_out_wr_data from the full-precision product fm*gate_reg (2*DATA_W signed), add 2^(GATE_FRAC-1), arithmetic-shift right by GATE_FRAC, and saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-017 SHALL NOT update gate_reg until the last product of the previous pixel is registered; the sequence of REQ-014 guarantees this.
REQ-018 DRAIN SHALL wait for the final write (address VP*IN_CH-1); the next enabled cycle SHALL be DONE.
REQ-019 DONE SHALL assert o_done=1 for exactly one enabled cycle and then return to IDLE.
REQ-020 SHALL deassert o_fm_rd_en and o_out_wr_en whenever no valid read or write is pending, with o_out_wr_en a single-cycle strobe per sample.
REQ-021 A downstream memory SHALL treat a write as occurring only on edges where both i_clk_en=1 and o_out_wr_en=1.

Reset
REQ-022 On rst_n=0, asynchronously: state=IDLE; o_done, o_busy, o_fm_rd_en and o_out_wr_en = 0; all addresses, o_out_wr_data, gate_reg and counters = 0.
REQ-023 Reset asserted mid-operation SHALL abort the frame with no further writes, and SHALL require a new i_start to run.

Structure
REQ-024 A shared package SHALL hold the state encodings, the derived constants VP, OUT_COUNT=VP*IN_CH and K_OFF=K_DIM/2, and the default GATE_FRAC.
REQ-025 The multiply/round/saturate datapath SHALL be one registered sub-module, gate_mul_sat, with 1-cycle latency.

Verification
REQ-026 Defaults, all gates=64, FM[a]=a mod 128, i_clk_en=1 -> 48 writes; write 0 carries FM addr 48 data 48; write 47 carries FM addr 111 data 111; o_done rises 1 cycle after the last write; total 60 pipeline cycles + drain + DONE.
REQ-027 Arithmetic: fm=-3, gate=32 -> -1; fm=127, gate=64 -> 127; fm=-128, gate=64 -> -128; fm=100, gate=0 -> 0; fm=5, gate=-64 -> -5.
REQ-028 i_clk_en toggling randomly (~50%) -> write sequence and data identical to REQ-026, with no duplicate or lost writes.
REQ-029 i_start pulsed during CH_RUN -> ignored; exactly 48 writes and one o_done.
REQ-030 rst_n low at write 20 -> outputs zero immediately; no writes until a new i_start; the rerun matches REQ-026.
REQ-031 Back-to-back frames (i_start in the cycle after o_done) -> the second frame produces 48 correct writes.
